decode_stage: RTL
=================

Name: decode_stage

Overview:
- Pipeline stage directly downstream of the instruction fetch stage.
- Accepts one 32-bit MIPS-style instruction per cycle, plus its PC, over a valid/ready handshake.
- Splits the instruction into fields, extends the immediate, reads two operands from an internal 32x32 register file and computes the destination register.
- Presents the result as a registered bundle to the execute stage; the register file write port is driven by writeback.

Parameters:
- PC_W, 32, width of the PC carried alongside each instruction.
- NREGS, 32, number of architectural registers (5-bit index).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  PC_W  PC of in_inst.
- flush  in  1  discard the held instruction (branch redirect).
- wb_en  in  1  register file write enable.
- wb_addr  in  5  write index.
- wb_data  in  32  write data.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_pc  out  PC_W  PC of the decoded instruction.
- out_opcode  out  6  inst[31:26].
- out_funct  out  6  inst[5:0].
- out_rs, out_rt, out_rd, out_shamt  out  5 each  inst[25:21], [20:16], [15:11], [10:6].
- out_rs_val, out_rt_val  out  32 each  register operands.
- out_imm  out  32  extended immediate.
- out_jtarget  out  26  inst[25:0].
- out_type  out  2  0=R, 1=I, 2=J.
- out_dest  out  5  register written by the instruction; 0 if none.
- out_illegal  out  1  unsupported opcode.

Behaviour:
- Reset: all outputs register to 0 (out_valid=0), and all register file entries clear to 0. in_ready=1 once out_valid=0.
- Handshake: in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
  - On accept, the whole bundle is loaded on that edge and out_valid=1. Latency is 1 cycle.
  - On out_ready && out_valid with no accept, out_valid goes to 0.
  - While out_valid && !out_ready, all out_* hold stable.
- Flush: has priority over accept. On the flush edge out_valid becomes 0 and the incoming instruction is dropped, even if in_valid=1 and in_ready=1.
- Rst has priority over flush.
- Supported opcodes:
  - 0x00 R: type=0, dest=rd.
  - 0x02 J: type=2, dest=0.
  - 0x03 JAL: type=2, dest=31.
  - 0x04 BEQ and 0x05 BNE: type=1, dest=0.
  - 0x08 ADDI: type=1, dest=rt.
  - 0x0C ANDI and 0x0D ORI: type=1, dest=rt.
  - 0x0F LUI: type=1, dest=rt.
  - 0x23 LW: type=1, dest=rt.
  - 0x2B SW: type=1, dest=0.
  - Any other opcode: out_illegal=1, type=1, dest=0, and the bundle is still passed as valid.
- Immediate:
  - ANDI and ORI: zero-extend inst[15:0].
  - LUI: {inst[15:0],16'h0}.
  - All other opcodes: sign-extend inst[15:0].
  - The immediate is computed for every type; downstream ignores it where irrelevant.
- Register file:
  - Register 0 always reads 0; writes to index 0 are ignored.
  - Write occurs on the edge when wb_en=1.
  - Bypass: if wb_en && wb_addr==rs (nonzero) on the accept cycle, out_rs_val=wb_data. The same applies to rt.
  - Operands are captured at accept and do not update while the bundle is stalled.
- Fetch and writeback are independent; a writeback occurs even while the stage is stalled or flushed.

Test Plan:
- R-type: after reset, write r21=0x11111111 and r3=0x22222222. Send inst 0x02A33332, pc=0.
  - Next cycle required: out_valid=1, opcode=0, rs=21, rt=3, rd=6, shamt=12, funct=0x32.
  - Also required: rs_val=0x11111111, rt_val=0x22222222, type=0, dest=6, illegal=0.
- J and I back-to-back with out_ready=1: send 0x0AA33332 (pc=1), then 0x22A33332 (pc=2).
  - First bundle required: type=2, jtarget=0x2A33332, dest=0.
  - Second bundle required: opcode=0x08, imm=0x00003332, dest=3, one per cycle.
  - Extension cases: ADDI imm 0xFFF0 -> out_imm=0xFFFFFFF0. ORI 0xFFF0 -> out_imm=0x0000FFF0. LUI 0x1234 -> out_imm=0x12340000.
- Stall: hold out_ready=0 for 3 cycles with in_valid=1.
  - Required: in_ready=0 and out_* stable.
  - On out_ready=1, the next instruction is accepted in that same cycle, with no loss and no duplication.
- Bypass and r0: same-cycle wb_en=1, wb_addr=21, wb_data=0xDEADBEEF with an accept of rs=21 -> out_rs_val=0xDEADBEEF.
  - Writing r0=0x5 then reading rs=0 -> out_rs_val=0.
- Flush and reset: flush=1 with in_valid=1 -> out_valid=0 next cycle and the instruction is dropped.
  - rst mid-stall -> out_valid=0 and all registers read 0.
- Illegal: opcode 0x3F -> out_valid=1, out_illegal=1, dest=0.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: instruction decode pipeline stage with an internal 32x32 register file.
//
// Ports:
//   clk, rst                         clock and synchronous active-high reset
//   in_valid / in_ready              handshake with fetch; in_inst, in_pc carry the instruction
//   flush                            drops the held bundle and the incoming instruction
//   wb_en, wb_addr, wb_data          register file write port driven by writeback
//   out_valid / out_ready            handshake with execute
//   out_pc, out_opcode, out_funct    decoded bundle: PC and instruction fields
//   out_rs, out_rt, out_rd, out_shamt
//   out_rs_val, out_rt_val           register operands captured at accept
//   out_imm, out_jtarget             extended immediate and jump target
//   out_type, out_dest, out_illegal  format (0=R, 1=I, 2=J), destination register, unsupported opcode
module decode_stage #(
    parameter int PC_W  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [31:0]     wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [5:0]      out_opcode,
    output logic [5:0]      out_funct,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_shamt,
    output logic [31:0]     out_rs_val,
    output logic [31:0]     out_rt_val,
    output logic [31:0]     out_imm,
    output logic [25:0]     out_jtarget,
    output logic [1:0]      out_type,
    output logic [4:0]      out_dest,
    output logic            out_illegal
);
    logic [31:0]     r_rf [NREGS];
    logic            r_valid;
    logic [31:0]     r_inst;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_rs_val;
    logic [31:0]     r_rt_val;
    logic [31:0]     r_imm;
    logic [1:0]      r_type;
    logic [4:0]      r_dest;
    logic            r_ill;
    logic            w_accept;
    logic [5:0]      w_op;
    logic [4:0]      w_rs;
    logic [4:0]      w_rt;
    logic [15:0]     w_lo;
    logic [31:0]     w_imm;
    logic [31:0]     w_rs_val;
    logic [31:0]     w_rt_val;
    logic [1:0]      w_type;
    logic [4:0]      w_dest;
    logic            w_ill;

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_op     = in_inst[31:26];
    assign w_rs     = in_inst[25:21];
    assign w_rt     = in_inst[20:16];
    assign w_lo     = in_inst[15:0];

    // A write landing on the accept edge is forwarded so the bundle sees the new value.
    assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : (wb_en && wb_addr == w_rs) ? wb_data : r_rf[w_rs];
    assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : (wb_en && wb_addr == w_rt) ? wb_data : r_rf[w_rt];

    assign w_imm = (w_op == 6'h0C || w_op == 6'h0D) ? {16'h0, w_lo} :
                   (w_op == 6'h0F)                  ? {w_lo, 16'h0} :
                                                      {{16{w_lo[15]}}, w_lo};

    always_comb begin
        w_type = 2'd1;
        w_dest = 5'd0;
        w_ill  = 1'b0;
        case (w_op)
            6'h00: begin
                w_type = 2'd0;
                w_dest = in_inst[15:11];
            end
            6'h02: w_type = 2'd2;
            6'h03: begin
                w_type = 2'd2;
                w_dest = 5'd31;
            end
            6'h04, 6'h05, 6'h2B: w_dest = 5'd0;
            6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23: w_dest = w_rt;
            default: w_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_inst   <= '0;
            r_pc     <= '0;
            r_rs_val <= '0;
            r_rt_val <= '0;
            r_imm    <= '0;
            r_type   <= '0;
            r_dest   <= '0;
            r_ill    <= 1'b0;
            for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
        end else begin
            if (wb_en && wb_addr != 5'd0) r_rf[wb_addr] <= wb_data;
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid  <= 1'b1;
                r_inst   <= in_inst;
                r_pc     <= in_pc;
                r_rs_val <= w_rs_val;
                r_rt_val <= w_rt_val;
                r_imm    <= w_imm;
                r_type   <= w_type;
                r_dest   <= w_dest;
                r_ill    <= w_ill;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_valid;
    assign out_pc      = r_pc;
    assign out_opcode  = r_inst[31:26];
    assign out_rs      = r_inst[25:21];
    assign out_rt      = r_inst[20:16];
    assign out_rd      = r_inst[15:11];
    assign out_shamt   = r_inst[10:6];
    assign out_funct   = r_inst[5:0];
    assign out_jtarget = r_inst[25:0];
    assign out_rs_val  = r_rs_val;
    assign out_rt_val  = r_rt_val;
    assign out_imm     = r_imm;
    assign out_type    = r_type;
    assign out_dest    = r_dest;
    assign out_illegal = r_ill;
endmodule
